// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline-stage register: two-entry skid buffer with valid/ready, flush and bubble clearing.
// Optional stall/flush performance counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              ready_q;

  logic              accept;
  logic              drain;
  logic              main_free;

  assign accept    = in_valid & ready_q;
  assign drain     = main_valid & out_ready;
  assign main_free = ~main_valid | drain;

  // Main entry; its control field is forced to zero whenever it goes empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        main_ctrl  <= skid_ctrl;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
        main_ctrl  <= in_ctrl;
      end else begin
        main_valid <= 1'b0;
        main_ctrl  <= '0;
      end
    end
  end

  // Skid entry; flush only invalidates it, the payload registers keep their contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
    end else if (flush) begin
      skid_valid <= 1'b0;
    end else if (main_free) begin
      skid_valid <= 1'b0;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
      skid_ctrl  <= in_ctrl;
    end
  end

  // Registered ready mirrors the next-cycle skid occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ready_q <= 1'b1;
    end else if (main_free) begin
      ready_q <= 1'b1;
    end else if (accept) begin
      ready_q <= 1'b0;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;

`ifdef PIPE_STAGE_PERF_EN
  logic stall_evt;
  logic flush_evt;

  assign stall_evt = main_valid & ~out_ready;
  assign flush_evt = flush & (main_valid | skid_valid);

  // Saturating event counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush_evt && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: occupancy model plus payload scoreboard, checked every cycle.
module tb_pipe_stage_skid;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
`endif

  pipe_stage_skid #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_ctrl(in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_ctrl(out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [DATA_W+CTRL_W-1:0] sb[$];
  logic [DATA_W-1:0]        last_data;
  int                       stall_exp;
  int                       flush_exp;
  int                       tests;
  int                       fails;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = {d[7:0], 8'h3C};
  endtask

  // Checks the current outputs against the model, then advances the model and the clock together.
  task automatic step();
    bit exp_v;
    bit exp_r;
    bit drain;
    bit accept;
    exp_v = (sb.size() > 0);
    exp_r = (sb.size() < 2);
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_r});
    if (exp_v) begin
      chk("out_data", 64'(out_data), 64'(sb[0][DATA_W+CTRL_W-1:CTRL_W]));
      chk("out_ctrl", 64'(out_ctrl), 64'(sb[0][CTRL_W-1:0]));
      last_data = sb[0][DATA_W+CTRL_W-1:CTRL_W];
    end else begin
      chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
      chk("bubble_data_hold", 64'(out_data), 64'(last_data));
    end
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
    chk("flush_cnt", 64'(flush_cnt), 64'(flush_exp));
`endif
    drain  = exp_v & out_ready;
    accept = in_valid & exp_r;
    if (rst) begin
      sb.delete();
      last_data = '0;
      stall_exp = 0;
      flush_exp = 0;
    end else begin
      if (exp_v && !out_ready && stall_exp != CNT_MAX) stall_exp++;
      if (flush) begin
        if (exp_v && flush_exp != CNT_MAX) flush_exp++;
        sb.delete();
      end else begin
        if (drain) void'(sb.pop_front());
        if (accept) sb.push_back({in_data, in_ctrl});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    stall_exp = 0;
    flush_exp = 0;
    last_data = '0;
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF);
    in_ctrl = 16'hFFFF;

    // Reset for two cycles while upstream presents a valid entry.
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    drive(1'b0, 32'h0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_out_ctrl", 64'(out_ctrl), 64'd0);
    step();

    // Back-to-back stream with downstream always ready.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i));
      step();
    end
    drive(1'b0, 32'h0);
    step();
    step();
    chk("stream_bubble_data", 64'(out_data), 64'h8);

    // Stall: second entry lands in the skid, then both drain in order.
    out_ready = 1'b0;
    drive(1'b1, 32'hA);
    step();
    drive(1'b1, 32'hB);
    step();
    drive(1'b0, 32'h0);
    step();
    chk("skid_full_ready", {63'd0, in_ready}, 64'd0);
    step();
    out_ready = 1'b1;
    step();
    step();
    step();

    // Flush with both entries held; presented input is dropped.
    out_ready = 1'b0;
    drive(1'b1, 32'h11);
    step();
    drive(1'b1, 32'h12);
    step();
    flush = 1'b1;
    drive(1'b1, 32'hC);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    step();
    step();

    // Flush with only main held while ready is high; input still dropped.
    out_ready = 1'b0;
    drive(1'b1, 32'h21);
    step();
    flush = 1'b1;
    drive(1'b1, 32'hD);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    step();

    // Flush while empty must not count.
    flush = 1'b1;
    drive(1'b1, 32'hE);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    step();

    // Reset mid-operation with skid full and stalled.
    drive(1'b1, 32'h31);
    step();
    drive(1'b1, 32'h32);
    step();
    drive(1'b0, 32'h0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_data", 64'(out_data), 64'd0);
    out_ready = 1'b1;
    drive(1'b1, 32'h5);
    step();
    drive(1'b0, 32'h0);
    step();
    step();

    // Long stall to exercise counter saturation.
    out_ready = 1'b0;
    drive(1'b1, 32'h77);
    step();
    drive(1'b0, 32'h0);
    for (int i = 0; i < 5; i++) step();
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt_5", 64'(stall_cnt), 64'd5);
`endif
    for (int i = 0; i < 15; i++) step();
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt_sat", 64'(stall_cnt), 64'(CNT_MAX));
`endif
    out_ready = 1'b1;
    step();
    step();

    // Random traffic with occasional flush.
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom());
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      step();
    end
    flush = 1'b0;
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    step();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
